// File: rtl/mine_ctrl_pkg.sv
// Shared types and helpers for the mining sweep sequencer.
// The last-issue test is done in 33 bits so the base never wraps.
package mine_ctrl_pkg;

  localparam int NONCE_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SWEEP,
    DRAIN
  } sweep_state_t;

  function automatic logic last_issue(
    input logic [NONCE_W-1:0] base,
    input logic [NONCE_W-1:0] cores,
    input logic [NONCE_W-1:0] limit
  );
    logic [NONCE_W:0] top;
    top = {1'b0, base} + {1'b0, cores} - 33'd1;
    return top >= {1'b0, limit};
  endfunction

endpackage

// File: rtl/nonce_result_writer.sv
// Records decoder hits: job hit flag, buffer write register
// and a sticky overflow bit for hits dropped on a full buffer.
module nonce_result_writer
  import mine_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               accept,
  input  logic               result_valid,
  input  logic               result_success,
  input  logic [NONCE_W-1:0] result_nonce,
  input  logic               buf_full,
  output logic               buf_wr,
  output logic [NONCE_W-1:0] buf_nonce,
  output logic               buf_overflow,
  output logic               hit
);

  logic take;

  assign take = accept & result_valid & result_success;

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_wr       <= 1'b0;
      buf_nonce    <= '0;
      buf_overflow <= 1'b0;
      hit          <= 1'b0;
    end else if (clr) begin
      buf_wr       <= 1'b0;
      buf_overflow <= 1'b0;
      hit          <= 1'b0;
    end else begin
      buf_wr <= 1'b0;
      if (take) begin
        hit <= 1'b1;
        if (buf_full) begin
          buf_overflow <= 1'b1;
        end else begin
          buf_wr    <= 1'b1;
          buf_nonce <= result_nonce;
        end
      end
    end
  end

endmodule

// File: rtl/mine_sweep_ctrl.sv
// Mining sweep sequencer: load block, broadcast, issue nonce
// bases to the lattice, then drain in-flight results.
module mine_sweep_ctrl
  import mine_ctrl_pkg::*;
#(
  parameter int unsigned  NUM_CORES    = 10,
  parameter int unsigned  PIPE_LATENCY = 64,
  parameter logic [31:0]  NONCE_LIMIT  = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        blk_ready_i,
  output logic        blk_ack_o,
  output logic        bcast_start_o,
  input  logic        bcast_done_i,
  output logic        issue_valid_o,
  output logic [31:0] issue_base_o,
  input  logic        result_valid_i,
  input  logic        result_success_i,
  input  logic [31:0] result_nonce_i,
  output logic        buf_wr_o,
  output logic [31:0] buf_nonce_o,
  input  logic        buf_full_i,
  output logic        buf_overflow_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        hit_o
);

  sweep_state_t       state;
  logic [NONCE_W-1:0] base;
  logic [9:0]         drain_cnt;
  logic               take;
  logic               hit_now;
  logic               last;
  logic               drain_end;
  logic               hit_flag;

  assign take      = (state == IDLE) && blk_ready_i;
  assign hit_now   = result_valid_i & result_success_i;
  assign last      = last_issue(base, 32'(NUM_CORES), NONCE_LIMIT);
  assign drain_end = (state == DRAIN) && (drain_cnt == 10'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      base      <= '0;
      drain_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (take) state <= LOAD;
        end
        LOAD: begin
          if (bcast_done_i) begin
            state <= SWEEP;
            base  <= '0;
          end
        end
        SWEEP: begin
          // a hit ends the sweep just like the final base does
          if (last || hit_now) begin
            state     <= DRAIN;
            drain_cnt <= 10'(PIPE_LATENCY);
          end else begin
            base <= base + 32'(NUM_CORES);
          end
        end
        DRAIN: begin
          if (drain_cnt == 10'd0) state <= IDLE;
          else drain_cnt <= drain_cnt - 10'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign blk_ack_o     = take;
  assign bcast_start_o = take;
  assign issue_valid_o = (state == SWEEP);
  assign issue_base_o  = base;
  assign busy_o        = (state != IDLE);
  assign done_o        = drain_end;
  assign hit_o         = drain_end & hit_flag;

  nonce_result_writer u_writer (
    .clk            (clk),
    .rst            (rst),
    .clr            (take),
    .accept         (state != IDLE),
    .result_valid   (result_valid_i),
    .result_success (result_success_i),
    .result_nonce   (result_nonce_i),
    .buf_full       (buf_full_i),
    .buf_wr         (buf_wr_o),
    .buf_nonce      (buf_nonce_o),
    .buf_overflow   (buf_overflow_o),
    .hit            (hit_flag)
  );

endmodule

// File: tb/tb_mine_sweep_ctrl.sv
// Directed-plus-random bench for mine_sweep_ctrl with a
// job-level reference model and a second wide-core instance.
module tb_mine_sweep_ctrl;

  localparam int          LAT   = 8;
  localparam int          WLAT  = 3;
  localparam logic [31:0] WCORE = 32'h3333_3334;

  logic        clk = 1'b0;
  logic        rst;
  logic        blk_ready, bcast_done, rv, rs, buf_full;
  logic [31:0] rn;
  logic        blk_ack, bcast_start, issue_valid, buf_wr;
  logic        buf_ovf, busy, done, hit;
  logic [31:0] issue_base, buf_nonce;

  logic        w_ready, w_bdone;
  logic        w_ack, w_start, w_iv, w_wr, w_ovf, w_busy, w_done, w_hit;
  logic [31:0] w_base, w_nonce;

  int          total = 0;
  int          bad = 0;
  bit          active = 0;
  bit          clr_now = 0;
  bit          exp_wr = 0;
  bit          exp_ovf = 0;
  bit          exp_hit = 0;
  logic [31:0] exp_nonce = '0;

  always #5 clk = ~clk;

  mine_sweep_ctrl #(
    .NUM_CORES(10), .PIPE_LATENCY(LAT), .NONCE_LIMIT(32'd99)
  ) dut (
    .clk(clk), .rst(rst),
    .blk_ready_i(blk_ready), .blk_ack_o(blk_ack),
    .bcast_start_o(bcast_start), .bcast_done_i(bcast_done),
    .issue_valid_o(issue_valid), .issue_base_o(issue_base),
    .result_valid_i(rv), .result_success_i(rs),
    .result_nonce_i(rn),
    .buf_wr_o(buf_wr), .buf_nonce_o(buf_nonce),
    .buf_full_i(buf_full), .buf_overflow_o(buf_ovf),
    .busy_o(busy), .done_o(done), .hit_o(hit)
  );

  mine_sweep_ctrl #(
    .NUM_CORES(WCORE), .PIPE_LATENCY(WLAT),
    .NONCE_LIMIT(32'hFFFF_FFFF)
  ) dut_wide (
    .clk(clk), .rst(rst),
    .blk_ready_i(w_ready), .blk_ack_o(w_ack),
    .bcast_start_o(w_start), .bcast_done_i(w_bdone),
    .issue_valid_o(w_iv), .issue_base_o(w_base),
    .result_valid_i(1'b0), .result_success_i(1'b0),
    .result_nonce_i(32'd0),
    .buf_wr_o(w_wr), .buf_nonce_o(w_nonce),
    .buf_full_i(1'b0), .buf_overflow_o(w_ovf),
    .busy_o(w_busy), .done_o(w_done), .hit_o(w_hit)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_writer();
    chk("buf_wr", {31'd0, buf_wr}, {31'd0, exp_wr});
    if (exp_wr) chk("buf_nonce", buf_nonce, exp_nonce);
    chk("buf_ovf", {31'd0, buf_ovf}, {31'd0, exp_ovf});
  endtask

  // advance one cycle; the model consumes what was driven
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      exp_wr = 0; exp_ovf = 0; exp_hit = 0; exp_nonce = '0;
    end else if (clr_now) begin
      exp_wr = 0; exp_ovf = 0; exp_hit = 0;
    end else if (active && rv && rs) begin
      exp_hit = 1;
      if (buf_full) begin
        exp_ovf = 1; exp_wr = 0;
      end else begin
        exp_wr = 1; exp_nonce = rn;
      end
    end else begin
      exp_wr = 0;
    end
    clr_now = 0;
    @(negedge clk);
    rst = 0; blk_ready = 0; bcast_done = 0;
    rv = 0; rs = 0; rn = '0; buf_full = 0;
    w_ready = 0; w_bdone = 0;
  endtask

  // drain_prob < 0 selects the directed two-hit drain pattern
  task automatic job(input int bdelay, input int hit_k,
                     input int abort_k, input int drain_prob);
    int k;
    bit stop;
    blk_ready = 1;
    #1;
    chk("ack", {31'd0, blk_ack}, 32'd1);
    chk("bstart", {31'd0, bcast_start}, 32'd1);
    chk("busy_idle", {31'd0, busy}, 32'd0);
    chk_writer();
    clr_now = 1;
    tick();
    active = 1;
    for (int i = 0; i <= bdelay; i++) begin
      blk_ready  = 1'($urandom_range(0, 1));
      bcast_done = (i == bdelay);
      #1;
      chk("ack_load", {31'd0, blk_ack}, 32'd0);
      chk("iv_load", {31'd0, issue_valid}, 32'd0);
      chk("busy_load", {31'd0, busy}, 32'd1);
      chk_writer();
      tick();
    end
    k = 0;
    stop = 0;
    while (!stop) begin
      if (k == abort_k) begin
        rst = 1;
        #1;
        tick();
        active = 0;
        #1;
        chk("rst_ack", {31'd0, blk_ack}, 32'd0);
        chk("rst_iv", {31'd0, issue_valid}, 32'd0);
        chk("rst_base", issue_base, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_hit", {31'd0, hit}, 32'd0);
        chk("rst_nonce", buf_nonce, 32'd0);
        chk_writer();
        for (int i = 0; i < LAT + 2; i++) begin
          tick();
          #1;
          chk("rst_nodone", {31'd0, done}, 32'd0);
        end
        return;
      end
      rv = (k == hit_k) ? 1'b1 : 1'($urandom_range(0, 1));
      rs = (k == hit_k) ? 1'b1 : (rv ? 1'b0 : 1'($urandom_range(0, 1)));
      rn = $urandom;
      buf_full = (k == hit_k) ? 1'b0 : 1'($urandom_range(0, 1));
      #1;
      chk("iv", {31'd0, issue_valid}, 32'd1);
      chk("base", issue_base, 32'(10 * k));
      chk("done_sweep", {31'd0, done}, 32'd0);
      chk_writer();
      stop = (10 * k + 9 >= 99) || (rv && rs);
      tick();
      k++;
    end
    for (int i = 0; i <= LAT; i++) begin
      if (drain_prob < 0) begin
        rv = (i == 1) || (i == 3);
        rs = rv;
        buf_full = (i == 3);
      end else begin
        rv = ($urandom_range(0, 99) < drain_prob);
        rs = 1'($urandom_range(0, 1));
        buf_full = 1'($urandom_range(0, 1));
      end
      rn = $urandom;
      #1;
      chk("iv_drain", {31'd0, issue_valid}, 32'd0);
      chk("busy_drain", {31'd0, busy}, 32'd1);
      chk("done", {31'd0, done}, {31'd0, i == LAT});
      chk("hit_o", {31'd0, hit}, {31'd0, (i == LAT) && exp_hit});
      chk_writer();
      tick();
    end
    active = 0;
    #1;
    chk("busy_after", {31'd0, busy}, 32'd0);
    chk("done_after", {31'd0, done}, 32'd0);
    chk_writer();
  endtask

  initial begin
    longint unsigned b;
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    rst = 1; blk_ready = 0; bcast_done = 0;
    rv = 0; rs = 0; rn = '0; buf_full = 0;
    w_ready = 0; w_bdone = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    chk("reset_ack", {31'd0, blk_ack}, 32'd0);
    chk("reset_iv", {31'd0, issue_valid}, 32'd0);
    chk("reset_base", issue_base, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_hit", {31'd0, hit}, 32'd0);
    chk_writer();

    // hit presented while idle is ignored
    rv = 1; rs = 1; rn = 32'hDEAD_BEEF;
    #1;
    tick();
    #1;
    chk_writer();

    job(4, -1, -1, 0);
    job(2, 6, -1, 0);
    job(1, -1, -1, -1);
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      chk_writer();
    end
    job(3, -1, 4, 0);
    job(0, -1, -1, 0);
    for (int j = 0; j < 4; j++)
      job($urandom_range(0, 6), $urandom_range(0, 12), -1, 30);

    // wide-core instance: final base must stop before 2^32
    b = 0;
    forever begin
      exp_q.push_back(32'(b));
      if (b + longint'(WCORE) - 1 >= 64'hFFFF_FFFF) break;
      b += longint'(WCORE);
    end
    w_ready = 1;
    #1;
    chk("w_ack", {31'd0, w_ack}, 32'd1);
    tick();
    w_bdone = 1;
    #1;
    tick();
    for (int c = 0; c < 20; c++) begin
      #1;
      if (!w_iv) break;
      got_q.push_back(w_base);
      tick();
    end
    chk("w_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk("w_base", got_q[i], exp_q[i]);
    chk("w_busy_drain", {31'd0, w_busy}, 32'd1);
    for (int i = 0; i <= WLAT; i++) begin
      chk("w_done", {31'd0, w_done}, {31'd0, i == WLAT});
      tick();
      #1;
    end
    chk("w_busy_after", {31'd0, w_busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
